fft_bf_addr_gen: RTL and testbench

//  Sequencer directly upstream of fft_butterfly in the in-place radix-2 DIT FFT/IFFT engine.

---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_bf_addr_calc.sv | 33 +++
 rtl/fft_bf_addr_gen.sv | 130 +++++++++++++
 tb/tb_fft_bf_addr_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and width helpers for the radix-2 DIT FFT butterfly address sequencer.
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FINISH
   } state_t;

   localparam int LOG2_N_DEF     = 6;
   localparam int PIPE_DEPTH_DEF = 2;

   function automatic int stage_w(input int log2_n);
      return $clog2(log2_n);
   endfunction

   // A zero or one-cycle drain still needs a one-bit counter to keep the type legal.
   function automatic int drain_w(input int pipe_depth);
      return (pipe_depth > 1) ? $clog2(pipe_depth) : 1;
   endfunction

endpackage

// File: rtl/fft_bf_addr_calc.sv
// Combinational (stage, butterfly index) -> operand and twiddle addresses for in-place radix-2 DIT.
module fft_bf_addr_calc
   import fft_pkg::*;
#(
   parameter int LOG2_N = LOG2_N_DEF
) (
   input  logic [stage_w(LOG2_N)-1:0] stage,
   input  logic [LOG2_N-2:0]          k,
   output logic [LOG2_N-1:0]          addr0,
   output logic [LOG2_N-1:0]          addr1,
   output logic [LOG2_N-2:0]          tw_addr
);
   localparam int STAGE_W = stage_w(LOG2_N);

   logic [LOG2_N-2:0]  low_mask;
   logic [LOG2_N-2:0]  j;
   logic [LOG2_N-2:0]  g_hi;
   logic [LOG2_N-1:0]  h;
   logic [STAGE_W-1:0] tw_shift;

   // addr0 is k with a zero bit inserted at position s: low bits are j, high bits are g<<(s+1).
   always_comb begin
      low_mask = ~({(LOG2_N-1){1'b1}} << stage);
      j        = k & low_mask;
      g_hi     = k & ~low_mask;
      h        = {{(LOG2_N-1){1'b0}}, 1'b1} << stage;
      addr0    = {g_hi, 1'b0} | {1'b0, j};
      addr1    = addr0 | h;
      tw_shift = STAGE_W'(LOG2_N - 1) - stage;
      tw_addr  = j << tw_shift;
   end

endmodule

// File: rtl/fft_bf_addr_gen.sv
// Butterfly sequencer for the in-place radix-2 DIT FFT: walks stages x butterflies, issuing
// operand and twiddle addresses under valid/ready and draining the pipeline between stages.
module fft_bf_addr_gen
   import fft_pkg::*;
#(
   parameter int LOG2_N     = LOG2_N_DEF,
   parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       fft_ifft,
   output logic                       busy,
   output logic                       done,
   output logic                       bf_valid,
   input  logic                       bf_ready,
   output logic [LOG2_N-1:0]          addr0,
   output logic [LOG2_N-1:0]          addr1,
   output logic [LOG2_N-2:0]          tw_addr,
   output logic                       tw_conj,
   output logic [stage_w(LOG2_N)-1:0] stage,
   output logic                       last_in_stage
);
   localparam int STAGE_W = stage_w(LOG2_N);
   localparam int K_W     = LOG2_N - 1;
   localparam int DRAIN_W = drain_w(PIPE_DEPTH);

   localparam logic [K_W-1:0]     K_LAST = '1;
   localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2_N - 1);
   localparam logic [DRAIN_W-1:0] D_LAST = DRAIN_W'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);

   state_t             state, state_nx;
   logic [STAGE_W-1:0] s, s_nx;
   logic [K_W-1:0]     k, k_nx;
   logic [DRAIN_W-1:0] dcnt, dcnt_nx;
   logic [LOG2_N-1:0]  c_addr0, c_addr1;
   logic [LOG2_N-2:0]  c_tw;

   // Addresses are computed for the next (s,k) so the registered outputs line up with the state.
   fft_bf_addr_calc #(
      .LOG2_N(LOG2_N)
   ) u_calc (
      .stage  (s_nx),
      .k      (k_nx),
      .addr0  (c_addr0),
      .addr1  (c_addr1),
      .tw_addr(c_tw)
   );

   always_comb begin
      state_nx = state;
      s_nx     = s;
      k_nx     = k;
      dcnt_nx  = dcnt;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = RUN;
               s_nx     = '0;
               k_nx     = '0;
            end
         end
         RUN: begin
            if (bf_ready) begin
               if (k != K_LAST) begin
                  k_nx = k + K_W'(1);
               end else if (PIPE_DEPTH != 0) begin
                  state_nx = DRAIN;
                  dcnt_nx  = '0;
               end else if (s != S_LAST) begin
                  s_nx = s + STAGE_W'(1);
                  k_nx = '0;
               end else begin
                  state_nx = FINISH;
               end
            end
         end
         DRAIN: begin
            if (dcnt != D_LAST) begin
               dcnt_nx = dcnt + DRAIN_W'(1);
            end else if (s != S_LAST) begin
               state_nx = RUN;
               s_nx     = s + STAGE_W'(1);
               k_nx     = '0;
            end else begin
               state_nx = FINISH;
            end
         end
         FINISH: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         s             <= '0;
         k             <= '0;
         dcnt          <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         bf_valid      <= 1'b0;
         addr0         <= '0;
         addr1         <= '0;
         tw_addr       <= '0;
         tw_conj       <= 1'b0;
         stage         <= '0;
         last_in_stage <= 1'b0;
      end else begin
         state         <= state_nx;
         s             <= s_nx;
         k             <= k_nx;
         dcnt          <= dcnt_nx;
         busy          <= (state_nx == RUN) || (state_nx == DRAIN);
         done          <= (state_nx == FINISH);
         bf_valid      <= (state_nx == RUN);
         last_in_stage <= (state_nx == RUN) && (k_nx == K_LAST);
         if ((state == IDLE) && start) begin
            tw_conj <= fft_ifft;
         end
         if (state_nx == RUN) begin
            addr0   <= c_addr0;
            addr1   <= c_addr1;
            tw_addr <= c_tw;
            stage   <= s_nx;
         end
      end
   end

endmodule

// File: tb/tb_fft_bf_addr_gen.sv
// Bench for fft_bf_addr_gen: two configurations checked cycle by cycle against an arithmetic reference.
module tb_fft_bf_addr_gen;

   logic clk = 1'b0;
   logic rst_n, start, fft_ifft, bf_ready, sel;
   logic start_a, start_b;

   logic       a_busy, a_done, a_valid, a_conj, a_last;
   logic [2:0] a_addr0, a_addr1;
   logic [1:0] a_tw, a_stage;

   logic       b_busy, b_done, b_valid, b_conj, b_last;
   logic [5:0] b_addr0, b_addr1;
   logic [4:0] b_tw;
   logic [2:0] b_stage;

   logic       o_busy, o_done, o_valid, o_conj, o_last;
   logic [5:0] o_addr0, o_addr1;
   logic [4:0] o_tw;
   logic [2:0] o_stage;

   int n_chk, n_bad, dc;

   always #5 clk = ~clk;

   assign start_a = start & ~sel;
   assign start_b = start & sel;

   fft_bf_addr_gen #(.LOG2_N(3), .PIPE_DEPTH(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .fft_ifft(fft_ifft),
      .busy(a_busy), .done(a_done), .bf_valid(a_valid), .bf_ready(bf_ready),
      .addr0(a_addr0), .addr1(a_addr1), .tw_addr(a_tw), .tw_conj(a_conj),
      .stage(a_stage), .last_in_stage(a_last)
   );

   fft_bf_addr_gen #(.LOG2_N(6), .PIPE_DEPTH(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .fft_ifft(fft_ifft),
      .busy(b_busy), .done(b_done), .bf_valid(b_valid), .bf_ready(bf_ready),
      .addr0(b_addr0), .addr1(b_addr1), .tw_addr(b_tw), .tw_conj(b_conj),
      .stage(b_stage), .last_in_stage(b_last)
   );

   always_comb begin
      if (sel) begin
         o_busy = b_busy; o_done = b_done; o_valid = b_valid; o_conj = b_conj; o_last = b_last;
         o_addr0 = b_addr0; o_addr1 = b_addr1; o_tw = b_tw; o_stage = b_stage;
      end else begin
         o_busy = a_busy; o_done = a_done; o_valid = a_valid; o_conj = a_conj; o_last = a_last;
         o_addr0 = {3'b000, a_addr0}; o_addr1 = {3'b000, a_addr1};
         o_tw = {3'b000, a_tw}; o_stage = {1'b0, a_stage};
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_valid"}, o_valid, 0);
      chk({tag, "_addr0"}, o_addr0, 0);
      chk({tag, "_addr1"}, o_addr1, 0);
      chk({tag, "_tw"}, o_tw, 0);
      chk({tag, "_conj"}, o_conj, 0);
      chk({tag, "_stage"}, o_stage, 0);
      chk({tag, "_last"}, o_last, 0);
   endtask

   // mode: 0 ready=1, 1 three-cycle stall at stage1 k=2, 2 random ready,
   //       3 reset at stage1 k=1, 4 fft_ifft toggle plus ignored starts
   task automatic do_run(input int ln, input int pd, input int mode, input bit inv,
                         output int done_cyc);
      int  n2, total, hs, drain, cyc, stalls, s, k, h, j, g, a0, a1, tw;
      bit  ev, exp_done, rdy, fin;
      n2 = 1 << (ln - 1);
      total = ln * n2;
      hs = 0; drain = 0; stalls = 0; done_cyc = -1; fin = 1'b0;
      @(negedge clk);
      fft_ifft = inv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (!fin) begin
         exp_done = (hs == total) && (drain == 0);
         ev = !exp_done && (drain == 0);
         rdy = 1'b1;
         if (mode == 1 && ev && hs == n2 + 2 && stalls < 3) begin
            rdy = 1'b0;
            stalls++;
         end
         if (mode == 2) rdy = ($urandom_range(0, 3) != 0);
         bf_ready = rdy;
         if (mode == 4) begin
            if (cyc == 5) begin start = 1'b1; fft_ifft = !inv; end
            if (cyc == 6) start = 1'b0;
            if (exp_done) start = 1'b1;
         end
         if (mode == 3 && ev && hs == n2 + 1) begin
            rst_n = 1'b0;
            #1;
            chk_all_zero("abort");
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         chk("valid", o_valid, ev);
         chk("busy", o_busy, !exp_done);
         chk("done", o_done, exp_done);
         chk("conj", o_conj, inv);
         if (ev) begin
            s = hs / n2;
            k = hs % n2;
            h = 1 << s;
            j = k % h;
            g = k / h;
            a0 = g * 2 * h + j;
            a1 = a0 + h;
            tw = j * (n2 / h);
            chk("stage", o_stage, s);
            chk("addr0", o_addr0, a0);
            chk("addr1", o_addr1, a1);
            chk("tw_addr", o_tw, tw);
            chk("last", o_last, k == n2 - 1);
         end
         if (exp_done) begin
            done_cyc = cyc;
            fin = 1'b1;
         end else if (cyc > 4 * total + 100) begin
            chk("timeout", cyc, 0);
            fin = 1'b1;
         end
         if (ev && rdy) begin
            hs++;
            if (hs % n2 == 0) drain = pd;
         end else if (drain > 0) begin
            drain--;
         end
         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end
      @(negedge clk);
      start = 1'b0;
      chk("idle_busy", o_busy, 0);
      chk("idle_done", o_done, 0);
      chk("idle_valid", o_valid, 0);
   endtask

   initial begin
      n_chk = 0; n_bad = 0;
      rst_n = 1'b0; start = 1'b0; fft_ifft = 1'b0; bf_ready = 1'b0; sel = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         sel = i[0];
         #1;
         chk_all_zero("reset");
      end
      sel = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk_all_zero("idle");

      do_run(3, 2, 0, 1'b0, dc);
      chk("done_cyc_base", dc, 19);
      do_run(3, 2, 1, 1'b0, dc);
      chk("done_cyc_stall", dc, 22);
      do_run(3, 2, 4, 1'b1, dc);
      chk("done_cyc_ifft", dc, 19);
      do_run(3, 2, 3, 1'b0, dc);
      do_run(3, 2, 0, 1'b0, dc);
      chk("done_cyc_after_abort", dc, 19);

      sel = 1'b1;
      @(negedge clk);
      do_run(6, 0, 0, 1'b0, dc);
      chk("done_cyc_pd0", dc, 193);
      do_run(6, 0, 2, 1'($urandom_range(0, 1)), dc);
      do_run(6, 0, 2, 1'($urandom_range(0, 1)), dc);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
